// File: rtl/spi_reg_bank.sv
// spi_reg_bank
//   SPI mode-0 peripheral exposing NUM_REGS configuration registers of DATA_W
//   bits. SCLK, COPI and nCS are synchronised into the clk domain; all frame
//   handling runs on clk. A frame is [RW][ADDR][DATA], MSB first, RW=1 writes.
//
//   Optional feature macro: SPI_READBACK_EN
//     defined   : read frames (RW=0) return regs_out[addr] on CIPO
//     undefined : CIPO tied low, read frames are only length/address checked
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   SCLK       SPI clock (CPOL=0), asynchronous
//   COPI       SPI data in, asynchronous
//   nCS        SPI chip select, active low, asynchronous
//   CIPO       SPI data out (read-back data phase only)
//   regs_out   flat register bank, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe  1-clk pulse when a register is written
//   wr_addr    address of the last committed write
//   frame_err  1-clk pulse when a frame is rejected
//
// state     | meaning
// ----------+--------------------------------------------------------------
// WAIT_IDLE | wait for nCS high; entry after reset, drops a partial frame
// IDLE      | wait for nCS fall, then clear counter and shift register
// SHIFT     | count SCLK rises and shift COPI until nCS rises
// COMMIT    | one clk: validate frame, write register or flag frame_err
module spi_reg_bank #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_LEN + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   sclk_s, copi_s, ncs_s, sclk_rise, sclk_fall;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [DATA_W-1:0]      regs_d [NUM_REGS];
  logic                   wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic                   frame_err_q, frame_err_d;

  logic                   frame_rw, frame_ok;
  logic [ADDR_W-1:0]      frame_addr;
  logic [DATA_W-1:0]      frame_data;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign frame_rw   = shift_q[FRAME_LEN-1];
  assign frame_addr = shift_q[FRAME_LEN-2 -: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];
  assign frame_ok   = (cnt_q == CNT_FULL) && ({1'b0, frame_addr} < NUM_REGS_X);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], COPI};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], nCS};
    sclk_prev_d = sclk_s;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    case (state_q)
      WAIT_IDLE: if (ncs_s) state_d = IDLE;
      // WAIT_IDLE guarantees nCS was high, so a low level here is a fall.
      IDLE: begin
        if (!ncs_s) begin
          cnt_d   = '0;
          shift_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          if (cnt_q < CNT_FULL) shift_d = {shift_q[FRAME_LEN-2:0], copi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
        if (ncs_s) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (!frame_ok) begin
          frame_err_d = 1'b1;
        end else if (frame_rw) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (frame_addr == ADDR_W'(k)) regs_d[k] = frame_data;
          end
          wr_strobe_d = 1'b1;
          wr_addr_d   = frame_addr;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // nCS synchroniser resets low so a reset during an active frame holds the
  // FSM in WAIT_IDLE until the real pin level is seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_out[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
  localparam int RD_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_PRE_ADDR = CNT_W'(ADDR_W);

  logic [DATA_W-1:0] shadow_q, shadow_d, rd_word;
  logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic              rd_active_q, rd_active_d;
  logic              cipo_q, cipo_d;
  logic [ADDR_W-1:0] rd_addr;

  // Address as it stands once the rise completing the address field lands.
  assign rd_addr = shift_d[ADDR_W-1:0];

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == ADDR_W'(k)) rd_word = regs_q[k];
    end
  end

  // rd_cnt counts data-phase falls; the fall after the last data bit
  // returns CIPO to 0.
  always_comb begin
    shadow_d    = shadow_q;
    rd_cnt_d    = rd_cnt_q;
    rd_active_d = rd_active_q;
    cipo_d      = cipo_q;
    if (state_q != SHIFT) begin
      rd_active_d = 1'b0;
      cipo_d      = 1'b0;
    end else begin
      if (sclk_rise && (cnt_q == CNT_PRE_ADDR) && !shift_d[ADDR_W]) begin
        shadow_d    = rd_word;
        rd_cnt_d    = '0;
        rd_active_d = 1'b1;
      end
      if (sclk_fall && rd_active_q) begin
        if (rd_cnt_q != RD_W'(DATA_W)) begin
          cipo_d   = shadow_q[DATA_W-1];
          shadow_d = shadow_q << 1;
          rd_cnt_d = rd_cnt_q + RD_W'(1);
        end else begin
          cipo_d      = 1'b0;
          rd_active_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      rd_cnt_q    <= '0;
      rd_active_q <= 1'b0;
      cipo_q      <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_active_q <= rd_active_d;
      cipo_q      <= cipo_d;
    end
  end

  assign CIPO = cipo_q;
`else
  assign CIPO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int NUM_REGS = 5;

  logic clk, rst_n, SCLK, COPI, nCS, CIPO;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic wr_strobe, frame_err;
  logic [ADDR_W-1:0] wr_addr;

  int n_vec = 0;
  int n_bad = 0;
  int n_strobe = 0;
  int n_err = 0;
  logic [31:0] rx_bits;
  logic [7:0] m_regs [NUM_REGS];

  spi_reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS), .CIPO(CIPO),
    .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) n_strobe++;
    if (frame_err === 1'b1) n_err++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [39:0] model_flat();
    logic [39:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[k*8 +: 8] = m_regs[k];
    return f;
  endfunction

  task automatic cs_low();
    @(negedge clk);
    nCS = 1'b0;
    rx_bits = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    nCS = 1'b1;
  endtask

  task automatic gap();
    repeat (8) @(negedge clk);
  endtask

  // Mode 0 master: COPI set while SCLK low, CIPO captured at the rising edge.
  task automatic send_bits(input logic [31:0] word, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      COPI = word[i];
      repeat (5) @(negedge clk);
      SCLK = 1'b1;
      rx_bits = {rx_bits[30:0], CIPO};
      repeat (5) @(negedge clk);
      SCLK = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] word, input int nbits);
    cs_low();
    send_bits(word, nbits);
    cs_high();
    gap();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (regs_out !== 40'h0) begin n_bad++; $display("FAIL reset_regs: got %h expected 0", regs_out); end
    n_vec++; if (wr_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe); end
    n_vec++; if (wr_addr !== 7'h0) begin n_bad++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_vec++; if (CIPO !== 1'b0) begin n_bad++; $display("FAIL reset_cipo: got %b expected 0", CIPO); end
    rst_n = 1'b1;
    gap();
  endtask

  task automatic test_basic_write();
    int s0 = n_strobe;
    cs_low();
    send_bits(32'h82A5, 16);
    cs_high();
    repeat (4) @(negedge clk);
    n_vec++; if (regs_out[23:16] !== 8'hA5) begin n_bad++; $display("FAIL write_latency: reg2 got %h expected a5", regs_out[23:16]); end
    n_vec++; if (wr_strobe !== 1'b1) begin n_bad++; $display("FAIL write_strobe_high: got %b expected 1", wr_strobe); end
    @(negedge clk);
    n_vec++; if (wr_strobe !== 1'b0) begin n_bad++; $display("FAIL write_strobe_width: got %b expected 0", wr_strobe); end
    gap();
    n_vec++; if (regs_out !== 40'h00_00_A5_00_00) begin n_bad++; $display("FAIL write_regs: got %h expected 0000a50000", regs_out); end
    n_vec++; if (wr_addr !== 7'd2) begin n_bad++; $display("FAIL write_addr: got %h expected 2", wr_addr); end
    n_vec++; if (n_strobe - s0 !== 1) begin n_bad++; $display("FAIL write_strobe_count: got %0d expected 1", n_strobe - s0); end
  endtask

  task automatic test_readback();
    int s0 = n_strobe;
    logic [15:0] exp_rx;
`ifdef SPI_READBACK_EN
    exp_rx = 16'h00A5;
`else
    exp_rx = 16'h0000;
`endif
    frame(32'h0200, 16);
    n_vec++; if (rx_bits[15:0] !== exp_rx) begin n_bad++; $display("FAIL readback_data: got %h expected %h", rx_bits[15:0], exp_rx); end
    n_vec++; if (regs_out !== 40'h00_00_A5_00_00) begin n_bad++; $display("FAIL readback_regs: got %h expected 0000a50000", regs_out); end
    n_vec++; if (n_strobe - s0 !== 0) begin n_bad++; $display("FAIL readback_strobe: got %0d expected 0", n_strobe - s0); end
    n_vec++; if (CIPO !== 1'b0) begin n_bad++; $display("FAIL readback_cipo_idle: got %b expected 0", CIPO); end
  endtask

  task automatic test_short_frame();
    int s0 = n_strobe;
    int e0 = n_err;
    frame(32'h84FF >> 6, 10);
    n_vec++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL short_err: got %0d expected 1", n_err - e0); end
    n_vec++; if (n_strobe - s0 !== 0) begin n_bad++; $display("FAIL short_strobe: got %0d expected 0", n_strobe - s0); end
    n_vec++; if (regs_out !== 40'h00_00_A5_00_00) begin n_bad++; $display("FAIL short_regs: got %h expected 0000a50000", regs_out); end
    frame(32'h8411, 16);
    n_vec++; if (regs_out !== 40'h11_00_A5_00_00) begin n_bad++; $display("FAIL short_next_write: got %h expected 1100a50000", regs_out); end
  endtask

  task automatic test_bad_addr_long();
    int s0 = n_strobe;
    int e0 = n_err;
    frame(32'h8733, 16);
    n_vec++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL bad_addr_err: got %0d expected 1", n_err - e0); end
    n_vec++; if (regs_out !== 40'h11_00_A5_00_00) begin n_bad++; $display("FAIL bad_addr_regs: got %h expected 1100a50000", regs_out); end
    frame((32'h8133 << 1) | 32'h1, 17);
    n_vec++; if (n_err - e0 !== 2) begin n_bad++; $display("FAIL long_err: got %0d expected 2", n_err - e0); end
    n_vec++; if (regs_out[15:8] !== 8'h00) begin n_bad++; $display("FAIL long_reg1: got %h expected 00", regs_out[15:8]); end
    n_vec++; if (n_strobe - s0 !== 0) begin n_bad++; $display("FAIL bad_frames_strobe: got %0d expected 0", n_strobe - s0); end
  endtask

  task automatic test_reset_mid_frame();
    int s0, e0;
    cs_low();
    send_bits(32'h8155 >> 10, 6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (regs_out !== 40'h0) begin n_bad++; $display("FAIL midrst_regs: got %h expected 0", regs_out); end
    n_vec++; if ({wr_strobe, wr_addr, frame_err, CIPO} !== 10'h0) begin n_bad++; $display("FAIL midrst_outputs: got %h expected 0", {wr_strobe, wr_addr, frame_err, CIPO}); end
    @(negedge clk);
    rst_n = 1'b1;
    s0 = n_strobe;
    e0 = n_err;
    send_bits(32'h8155 & 32'h3FF, 10);
    cs_high();
    gap();
    n_vec++; if (regs_out !== 40'h0) begin n_bad++; $display("FAIL midrst_ignored: got %h expected 0", regs_out); end
    n_vec++; if ((n_strobe - s0) + (n_err - e0) !== 0) begin n_bad++; $display("FAIL midrst_pulses: got %0d expected 0", (n_strobe - s0) + (n_err - e0)); end
    frame(32'h8155, 16);
    n_vec++; if (regs_out !== 40'h00_00_00_55_00) begin n_bad++; $display("FAIL midrst_next_write: got %h expected 0000005500", regs_out); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [5] = '{16'h8001, 16'h8102, 16'h8203, 16'h8304, 16'h8405};
    int s0 = n_strobe;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      nCS = 1'b0;
      repeat (4) @(negedge clk);
      send_bits(32'(words[i]), 16);
      cs_high();
      repeat (5) @(negedge clk);
    end
    gap();
    n_vec++; if (regs_out !== 40'h05_04_03_02_01) begin n_bad++; $display("FAIL b2b_regs: got %h expected 0504030201", regs_out); end
    n_vec++; if (n_strobe - s0 !== 5) begin n_bad++; $display("FAIL b2b_strobes: got %0d expected 5", n_strobe - s0); end
    n_vec++; if (wr_addr !== 7'd4) begin n_bad++; $display("FAIL b2b_wr_addr: got %h expected 4", wr_addr); end
  endtask

  task automatic test_random();
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = 8'(k + 1);
    for (int n = 0; n < 40; n++) begin
      logic rw, valid;
      logic [6:0] addr;
      logic [7:0] data, exp_rd;
      logic [15:0] fr;
      logic [31:0] word;
      int nbits, kind, s0, e0;
      rw   = ($urandom_range(0, 3) != 0);
      addr = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 6));
      data = 8'($urandom);
      fr   = {rw, addr, data};
      kind = $urandom_range(0, 9);
      if (kind < 7) nbits = 16;
      else if (kind < 8) nbits = $urandom_range(1, 15);
      else nbits = $urandom_range(17, 20);
      if (nbits <= 16) word = 32'(fr) >> (16 - nbits);
      else word = (32'(fr) << (nbits - 16)) | ($urandom & ((32'd1 << (nbits - 16)) - 1));
      valid = (nbits == 16) && (addr < NUM_REGS);
`ifdef SPI_READBACK_EN
      exp_rd = (addr < NUM_REGS) ? m_regs[addr] : 8'h00;
`else
      exp_rd = 8'h00;
`endif
      if (valid && rw) m_regs[addr] = data;
      s0 = n_strobe;
      e0 = n_err;
      frame(word, nbits);
      n_vec++; if (regs_out !== model_flat()) begin n_bad++; $display("FAIL rand_regs[%0d]: got %h expected %h", n, regs_out, model_flat()); end
      n_vec++; if (n_strobe - s0 !== int'(valid && rw)) begin n_bad++; $display("FAIL rand_strobe[%0d]: got %0d expected %0d", n, n_strobe - s0, int'(valid && rw)); end
      n_vec++; if (n_err - e0 !== int'(!valid)) begin n_bad++; $display("FAIL rand_err[%0d]: got %0d expected %0d", n, n_err - e0, int'(!valid)); end
      n_vec++; if (CIPO !== 1'b0) begin n_bad++; $display("FAIL rand_cipo_idle[%0d]: got %b expected 0", n, CIPO); end
      if (valid && rw) begin
        n_vec++; if (wr_addr !== addr) begin n_bad++; $display("FAIL rand_wr_addr[%0d]: got %h expected %h", n, wr_addr, addr); end
      end
      if (nbits == 16 && !rw) begin
        n_vec++; if (rx_bits[15:0] !== {8'h00, exp_rd}) begin n_bad++; $display("FAIL rand_read[%0d]: got %h expected %h", n, rx_bits[15:0], {8'h00, exp_rd}); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    nCS   = 1'b1;
    SCLK  = 1'b0;
    COPI  = 1'b0;
    rx_bits = '0;
    test_reset();
    test_basic_write();
    test_readback();
    test_short_frame();
    test_bad_addr_long();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
